status_register_unit: RTL and testbench

- Producer side of the 4-bit `status` vector consumed by ConditionCheck in the ID stage.
- Holds the architectural NZCV register, written by flag-setting (S=1) instructions leaving the EXE stage.
- Gives ID a same-cycle forwarded view, so a conditional instruction directly behind a flag setter sees the new flags without stalling.
- Adds a small saved-status stack (SPSR-like) for exception entry/return, with sticky overflow/underflow errors.

---
 rtl/arm_status_pkg.sv | 57 +++++
 rtl/status_stack.sv | 67 ++++++
 rtl/status_register_unit.sv | 75 +++++++
 tb/tb_status_register_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/arm_status_pkg.sv
// Shared NZCV definitions: flag bit positions, the flag vector type and the
// condition-code encodings that ConditionCheck decodes against this register.
package arm_status_pkg;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

  typedef logic [3:0] nzcv_t;

  typedef enum logic [3:0] {
    EQ = 4'h0,
    NE = 4'h1,
    CS = 4'h2,
    CC = 4'h3,
    MI = 4'h4,
    PL = 4'h5,
    VS = 4'h6,
    VC = 4'h7,
    HI = 4'h8,
    LS = 4'h9,
    GE = 4'hA,
    LT = 4'hB,
    GT = 4'hC,
    LE = 4'hD,
    AL = 4'hE
  } cond_t;

  // Condition evaluation shared with ConditionCheck; encoding 4'hF never passes.
  function automatic logic cond_pass(input cond_t cond, input nzcv_t f);
    logic n, z, c, v;
    n = f[N_BIT];
    z = f[Z_BIT];
    c = f[C_BIT];
    v = f[V_BIT];
    case (cond)
      EQ:      cond_pass = z;
      NE:      cond_pass = ~z;
      CS:      cond_pass = c;
      CC:      cond_pass = ~c;
      MI:      cond_pass = n;
      PL:      cond_pass = ~n;
      VS:      cond_pass = v;
      VC:      cond_pass = ~v;
      HI:      cond_pass = c & ~z;
      LS:      cond_pass = ~c | z;
      GE:      cond_pass = (n == v);
      LT:      cond_pass = (n != v);
      GT:      cond_pass = ~z & (n == v);
      LE:      cond_pass = z | (n != v);
      AL:      cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/status_stack.sv
// DEPTH x 4 LIFO of saved NZCV values with an occupancy counter and sticky
// overflow/underflow flags. Simultaneous push and pop leave it untouched.
module status_stack
  import arm_status_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  nzcv_t                      wdata,
  output nzcv_t                      rdata,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf_err,
  output logic                       unf_err
);

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  nzcv_t          mem [DEPTH];
  logic [DW-1:0]  cnt;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  logic           do_push;
  logic           do_pop;

  assign full    = (cnt == DW'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~pop & ~full;
  assign do_pop  = pop & ~push & ~empty;
  assign wr_idx  = AW'(cnt);
  assign rd_idx  = AW'(cnt - DW'(1));
  assign rdata   = mem[rd_idx];
  assign depth   = cnt;

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clock) begin
    if (rst_n && do_push) begin
      mem[wr_idx] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      cnt     <= '0;
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (do_push) begin
        cnt <= cnt + DW'(1);
      end else if (do_pop) begin
        cnt <= cnt - DW'(1);
      end
      if (push && !pop && full) begin
        ovf_err <= 1'b1;
      end
      if (pop && !push && empty) begin
        unf_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/status_register_unit.sv
// Architectural NZCV register with same-cycle forwarding to ConditionCheck and
// a saved-status stack for exception entry and return.
module status_register_unit
  import arm_status_pkg::*;
#(
  parameter int    DEPTH       = 4,
  parameter nzcv_t RESET_FLAGS = 4'b0000
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       exe_valid,
  input  logic                       exe_s,
  input  logic [3:0]                 exe_flags,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  output logic [3:0]                 status,
  output logic [3:0]                 status_fwd,
  output logic [$clog2(DEPTH+1)-1:0] depth,
  output logic                       ovf_err,
  output logic                       unf_err
);

  logic  upd;
  logic  restore;
  nzcv_t stk_top;
  logic  stk_full;
  logic  stk_empty;

  assign upd     = exe_valid & exe_s & ~flush;
  assign restore = pop & ~push & ~stk_empty;

  // The forwarded value is exactly what status takes next, and what a push
  // saves, so one mux serves ID, the register and the stack.
  always_comb begin
    status_fwd = status;
    if (restore) begin
      status_fwd = stk_top;
    end else if (upd) begin
      status_fwd = exe_flags;
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      status <= RESET_FLAGS;
    end else begin
      status <= status_fwd;
    end
  end

  status_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clock   (clock),
    .rst_n   (rst_n),
    .push    (push),
    .pop     (pop),
    .wdata   (status_fwd),
    .rdata   (stk_top),
    .depth   (depth),
    .full    (stk_full),
    .empty   (stk_empty),
    .ovf_err (ovf_err),
    .unf_err (unf_err)
  );

  a_no_push_pop: assert property (@(posedge clock) disable iff (!rst_n) !(push && pop))
    else $warning("status_register_unit: push and pop requested in the same cycle");

  a_depth_bound: assert property (@(posedge clock) disable iff (!rst_n)
                                  stk_full |-> (depth == ($clog2(DEPTH+1))'(DEPTH)))
    else $warning("status_register_unit: full flag and depth disagree");

endmodule

// File: tb/tb_status_register_unit.sv
// Bench for status_register_unit: directed scenarios plus a randomized run
// against a queue-based model of the flag register and saved-status stack.
module tb_status_register_unit;

  localparam int DEPTH = 4;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       exe_valid;
  logic       exe_s;
  logic [3:0] exe_flags;
  logic       flush;
  logic       push;
  logic       pop;
  logic [3:0] status;
  logic [3:0] status_fwd;
  logic [2:0] depth;
  logic       ovf_err;
  logic       unf_err;

  int checks = 0;
  int errors = 0;

  logic [3:0] mq [$];
  logic [3:0] m_status;
  logic       m_ovf;
  logic       m_unf;

  status_register_unit #(
    .DEPTH       (DEPTH),
    .RESET_FLAGS (4'b0000)
  ) dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .exe_valid  (exe_valid),
    .exe_s      (exe_s),
    .exe_flags  (exe_flags),
    .flush      (flush),
    .push       (push),
    .pop        (pop),
    .status     (status),
    .status_fwd (status_fwd),
    .depth      (depth),
    .ovf_err    (ovf_err),
    .unf_err    (unf_err)
  );

  always #5 clock = ~clock;

  // Reference: what ConditionCheck should see this cycle.
  function automatic logic [3:0] model_fwd();
    logic u;
    u = exe_valid && exe_s && !flush;
    if (pop && !push && mq.size() > 0) return mq[mq.size()-1];
    if (u) return exe_flags;
    return m_status;
  endfunction

  task automatic model_update();
    logic       u;
    logic [3:0] saved;
    u = exe_valid && exe_s && !flush;
    if (!rst_n) begin
      mq.delete();
      m_status = 4'b0000;
      m_ovf    = 1'b0;
      m_unf    = 1'b0;
    end else if (push && pop) begin
      if (u) m_status = exe_flags;
    end else if (pop) begin
      if (mq.size() > 0) begin
        saved    = mq.pop_back();
        m_status = saved;
      end else begin
        m_unf = 1'b1;
        if (u) m_status = exe_flags;
      end
    end else if (push) begin
      if (u) m_status = exe_flags;
      if (mq.size() < DEPTH) mq.push_back(m_status);
      else m_ovf = 1'b1;
    end else if (u) begin
      m_status = exe_flags;
    end
  endtask

  task automatic drive(input logic rs, input logic v, input logic s, input logic [3:0] f,
                       input logic fl, input logic pu, input logic po);
    rst_n     = rs;
    exe_valid = v;
    exe_s     = s;
    exe_flags = f;
    flush     = fl;
    push      = pu;
    pop       = po;
  endtask

  task automatic tick();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 4'b0000, 0, 0, 0);
    tick();
    tick();
    drive(1, 0, 0, 4'b0000, 0, 0, 0);
    tick();
    checks++; if (status !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b expected 0000", status); end
    checks++; if (status_fwd !== 4'b0000) begin errors++; $display("FAIL reset_fwd: got %b expected 0000", status_fwd); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL reset_depth: got %0d expected 0", depth); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf_err); end
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b expected 0", unf_err); end
  endtask

  task automatic test_forward();
    drive(1, 1, 1, 4'b1010, 0, 0, 0);
    #2;
    checks++; if (status_fwd !== 4'b1010) begin errors++; $display("FAIL fwd_same_cycle: got %b expected 1010", status_fwd); end
    checks++; if (status !== 4'b0000) begin errors++; $display("FAIL fwd_status_before_edge: got %b expected 0000", status); end
    tick();
    checks++; if (status !== 4'b1010) begin errors++; $display("FAIL fwd_commit: got %b expected 1010", status); end
    drive(1, 1, 1, 4'b0101, 1, 0, 0);
    #2;
    checks++; if (status_fwd !== 4'b1010) begin errors++; $display("FAIL flush_fwd: got %b expected 1010", status_fwd); end
    tick();
    checks++; if (status !== 4'b1010) begin errors++; $display("FAIL flush_status: got %b expected 1010", status); end
  endtask

  task automatic test_sbit();
    drive(1, 1, 0, 4'b1111, 0, 0, 0);
    tick();
    checks++; if (status !== 4'b1010) begin errors++; $display("FAIL sbit_clear: got %b expected 1010", status); end
    drive(1, 0, 1, 4'bxxxx, 0, 0, 0);
    #2;
    checks++; if (status_fwd !== 4'b1010) begin errors++; $display("FAIL x_flags_fwd: got %b expected 1010", status_fwd); end
    tick();
    checks++; if (status !== 4'b1010) begin errors++; $display("FAIL x_flags_status: got %b expected 1010", status); end
  endtask

  task automatic test_stack_roundtrip();
    drive(1, 0, 0, 4'b0000, 0, 1, 0);
    tick();
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL rt_push1_depth: got %0d expected 1", depth); end
    drive(1, 1, 1, 4'b0101, 0, 0, 0);
    tick();
    checks++; if (status !== 4'b0101) begin errors++; $display("FAIL rt_upd: got %b expected 0101", status); end
    drive(1, 1, 1, 4'b0011, 0, 1, 0);
    tick();
    checks++; if (depth !== 3'd2) begin errors++; $display("FAIL rt_push2_depth: got %0d expected 2", depth); end
    checks++; if (status !== 4'b0011) begin errors++; $display("FAIL rt_push2_status: got %b expected 0011", status); end
    drive(1, 1, 1, 4'b1111, 0, 0, 1);
    #2;
    checks++; if (status_fwd !== 4'b0011) begin errors++; $display("FAIL rt_pop1_fwd: got %b expected 0011", status_fwd); end
    tick();
    checks++; if (status !== 4'b0011) begin errors++; $display("FAIL rt_pop1_status: got %b expected 0011", status); end
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL rt_pop1_depth: got %0d expected 1", depth); end
    drive(1, 0, 0, 4'b0000, 0, 0, 1);
    #2;
    checks++; if (status_fwd !== 4'b1010) begin errors++; $display("FAIL rt_pop2_fwd: got %b expected 1010", status_fwd); end
    tick();
    checks++; if (status !== 4'b1010) begin errors++; $display("FAIL rt_pop2_status: got %b expected 1010", status); end
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL rt_pop2_depth: got %0d expected 0", depth); end
    checks++; if ({ovf_err, unf_err} !== 2'b00) begin errors++; $display("FAIL rt_errors: got %b expected 00", {ovf_err, unf_err}); end
  endtask

  task automatic test_boundaries();
    for (int i = 0; i < DEPTH + 1; i++) begin
      drive(1, 0, 0, 4'b0000, 0, 1, 0);
      tick();
    end
    checks++; if (depth !== 3'd4) begin errors++; $display("FAIL full_depth: got %0d expected 4", depth); end
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL full_ovf: got %b expected 1", ovf_err); end
    checks++; if (unf_err !== 1'b0) begin errors++; $display("FAIL full_unf: got %b expected 0", unf_err); end
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 0, 0, 4'b0000, 0, 0, 1);
      tick();
    end
    checks++; if (depth !== 3'd0 || unf_err !== 1'b0) begin errors++; $display("FAIL drain: got depth %0d unf %b expected 0 0", depth, unf_err); end
    drive(1, 1, 1, 4'b1100, 0, 0, 1);
    #2;
    checks++; if (status_fwd !== 4'b1100) begin errors++; $display("FAIL empty_pop_fwd: got %b expected 1100", status_fwd); end
    tick();
    checks++; if (status !== 4'b1100) begin errors++; $display("FAIL empty_pop_status: got %b expected 1100", status); end
    checks++; if (unf_err !== 1'b1 || depth !== 3'd0) begin errors++; $display("FAIL empty_pop_unf: got unf %b depth %0d expected 1 0", unf_err, depth); end
    drive(1, 0, 0, 4'b0000, 0, 1, 0);
    tick();
    drive(1, 1, 1, 4'b0110, 0, 1, 1);
    tick();
    checks++; if (depth !== 3'd1) begin errors++; $display("FAIL pushpop_depth: got %0d expected 1", depth); end
    checks++; if (status !== 4'b0110) begin errors++; $display("FAIL pushpop_status: got %b expected 0110", status); end
    checks++; if ({ovf_err, unf_err} !== 2'b11) begin errors++; $display("FAIL pushpop_errors: got %b expected 11", {ovf_err, unf_err}); end
    drive(1, 1, 1, 4'b1111, 0, 0, 1);
    tick();
    checks++; if (status !== 4'b1100) begin errors++; $display("FAIL pop_beats_upd: got %b expected 1100", status); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 4'b0000, 0, 1, 0);
      tick();
    end
    checks++; if (depth !== 3'd3 || ovf_err !== 1'b1) begin errors++; $display("FAIL mid_pre: got depth %0d ovf %b expected 3 1", depth, ovf_err); end
    drive(0, 1, 1, 4'b1111, 0, 1, 0);
    tick();
    checks++; if (depth !== 3'd0) begin errors++; $display("FAIL mid_depth: got %0d expected 0", depth); end
    checks++; if ({ovf_err, unf_err} !== 2'b00) begin errors++; $display("FAIL mid_errors: got %b expected 00", {ovf_err, unf_err}); end
    checks++; if (status !== 4'b0000) begin errors++; $display("FAIL mid_status: got %b expected 0000", status); end
    drive(1, 0, 0, 4'b0000, 0, 0, 1);
    tick();
    checks++; if (unf_err !== 1'b1 || depth !== 3'd0) begin errors++; $display("FAIL mid_pop: got unf %b depth %0d expected 1 0", unf_err, depth); end
  endtask

  task automatic test_random();
    logic       rs, v, s, fl, pu, po;
    logic [3:0] f;
    logic [3:0] exp;
    for (int i = 0; i < 800; i++) begin
      rs = ($urandom_range(0, 63) != 0);
      v  = 1'($urandom_range(0, 1));
      s  = 1'($urandom_range(0, 1));
      fl = ($urandom_range(0, 3) == 0);
      pu = ($urandom_range(0, 2) == 0);
      po = ($urandom_range(0, 2) == 0);
      if (pu && po && $urandom_range(0, 7) != 0) po = 1'b0;
      f  = 4'($urandom);
      if (!(v && s && !fl) && $urandom_range(0, 1) == 1) f = 4'bxxxx;
      drive(rs, v, s, f, fl, pu, po);
      #2;
      exp = model_fwd();
      checks++; if (status_fwd !== exp) begin errors++; $display("FAIL rand_fwd[%0d]: got %b expected %b", i, status_fwd, exp); end
      tick();
      checks++; if (status !== m_status) begin errors++; $display("FAIL rand_status[%0d]: got %b expected %b", i, status, m_status); end
      checks++; if (depth !== 3'(mq.size())) begin errors++; $display("FAIL rand_depth[%0d]: got %0d expected %0d", i, depth, mq.size()); end
      checks++; if ({ovf_err, unf_err} !== {m_ovf, m_unf}) begin errors++; $display("FAIL rand_errors[%0d]: got %b expected %b", i, {ovf_err, unf_err}, {m_ovf, m_unf}); end
    end
  endtask

  initial begin
    drive(0, 0, 0, 4'b0000, 0, 0, 0);
    m_status = 4'b0000;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    #1;
    test_reset();
    test_forward();
    test_sbit();
    test_stack_roundtrip();
    test_boundaries();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
